// File: rtl/sha256_block_sequencer.sv
// sha256_block_sequencer
//   Control sequencer for the SHA-256 core. Streams one 512-bit block as
//   sixteen 32-bit words into the message schedule, then runs the
//   schedule/compression units for ROUNDS cycles and folds the result into
//   the running hash H0..H7. Blocks chain until one is flagged last, after
//   which the digest is presented with digest_valid.
//
// Ports
//   clk, reset_n         clock (rising edge), asynchronous active-low reset
//   start                begins a new message (honoured only when idle)
//   in_word/in_valid     message word stream, big-endian word order
//   in_last              marks the current block as final (sampled on word 15)
//   in_ready             a word is accepted this cycle when in_valid is high
//   msg_word/addr/we     schedule write port, strobed on accepted words only
//   round                round index to schedule and compression
//   comp_init            compression loads a..h from digest
//   comp_en              compression and schedule advance one round
//   comp_vars            compression working variables {a..h}, a in [255:224]
//   digest               running hash {H0..H7}, H0 in [255:224]
//   digest_valid         digest holds the final hash of the last message
//   busy                 high whenever not idle
//   done                 one-cycle pulse at message completion
module sha256_block_sequencer #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [31:0]  in_word,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [31:0]  msg_word,
    output logic [3:0]   msg_addr,
    output logic         msg_we,
    output logic [5:0]   round,
    output logic         comp_init,
    output logic         comp_en,
    input  logic [255:0] comp_vars,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INIT,
        ST_ROUND,
        ST_UPDATE,
        ST_DONE
    } state_t;

    localparam logic [5:0]   LAST_ROUND = 6'(ROUNDS - 1);
    localparam logic [255:0] H_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    state_t       state;
    state_t       state_next;
    logic [3:0]   word_cnt;
    logic [5:0]   round_cnt;
    logic         last_flag;
    logic [255:0] h_q;
    logic [255:0] h_sum;
    logic         accept;

    assign accept = in_valid && in_ready;
    assign digest = h_q;

    // Per-word modulo-2^32 add; words are independent so no carry crosses
    // a 32-bit boundary.
    always_comb begin
        h_sum = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            h_sum[i*32 +: 32] = h_q[i*32 +: 32] + comp_vars[i*32 +: 32];
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        msg_we     = 1'b0;
        msg_addr   = '0;
        msg_word   = in_word;
        round      = '0;
        comp_init  = 1'b0;
        comp_en    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (accept) begin
                    msg_we   = 1'b1;
                    msg_addr = word_cnt;
                    if (word_cnt == 4'd15) state_next = ST_INIT;
                end
            end
            ST_INIT: begin
                comp_init  = 1'b1;
                state_next = ST_ROUND;
            end
            ST_ROUND: begin
                comp_en = 1'b1;
                round   = round_cnt;
                if (round_cnt == LAST_ROUND) state_next = ST_UPDATE;
            end
            ST_UPDATE: begin
                state_next = last_flag ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt     <= '0;
            round_cnt    <= '0;
            last_flag    <= 1'b0;
            digest_valid <= 1'b0;
            h_q          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        h_q          <= H_IV;
                        digest_valid <= 1'b0;
                        word_cnt     <= '0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        // 4-bit counter wraps to 0 after word 15
                        word_cnt <= word_cnt + 4'd1;
                        if (word_cnt == 4'd15) last_flag <= in_last;
                    end
                end
                ST_INIT:   round_cnt    <= '0;
                ST_ROUND:  round_cnt    <= round_cnt + 6'd1;
                ST_UPDATE: h_q          <= h_sum;
                ST_DONE:   digest_valid <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
`timescale 1ns/1ps
module tb_sha256_block_sequencer;

    localparam int unsigned ROUNDS = 64;

    localparam logic [255:0] IV_V =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] TWO_B1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2 = {{15{32'h0}}, 32'h000001c0};
    localparam logic [255:0] TWO_DIG =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start = 1'b0;
    logic [31:0]  in_word = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [31:0]  msg_word;
    logic [3:0]   msg_addr;
    logic         msg_we;
    logic [5:0]   round;
    logic         comp_init;
    logic         comp_en;
    logic [255:0] comp_vars;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;
    logic         done;

    sha256_block_sequencer #(.ROUNDS(ROUNDS)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_word(in_word), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .msg_word(msg_word), .msg_addr(msg_addr), .msg_we(msg_we),
        .round(round), .comp_init(comp_init), .comp_en(comp_en), .comp_vars(comp_vars),
        .digest(digest), .digest_valid(digest_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int pulse_word = -1;
    bit force_ones = 1'b0;

    // ---------------- SHA-256 arithmetic ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [255:0] round_step(input logic [255:0] v, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = v;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Whole-block reference: schedule expansion, 64 rounds, feed-forward.
    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [255:0] v;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
        v = hin;
        for (int t = 0; t < 64; t++) v = round_step(v, K[t], w[t]);
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = hin[i*32 +: 32] + v[i*32 +: 32];
        return r;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int j = 0; j < 16; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- schedule/compression stand-in and monitor ----------------
    logic [511:0] wbuf = '0;
    logic [511:0] win  = '0;
    logic [255:0] vars = '0;
    int           cyc = 0;
    int           t_last = 0;
    int           t_first = 0;
    int           t_done = 0;
    int           done_cnt = 0;
    logic [3:0]   addr_log [$];

    assign comp_vars = force_ones ? '1 : vars;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (msg_we) begin
            wbuf[511 - 32*int'(msg_addr) -: 32] <= msg_word;
            addr_log.push_back(msg_addr);
            if (msg_addr == 4'd15) t_last <= cyc;
            if (msg_addr == 4'd0) t_first <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            t_done   <= cyc;
        end
        if (comp_init) begin
            vars <= digest;
            win  <= wbuf;
        end else if (comp_en) begin
            vars <= round_step(vars, K[round], win[511:480]);
            win  <= {win[479:0], ss1(win[63:32]) + win[223:192] + ss0(win[479:448]) + win[511:480]};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // mode 0: in_valid held high, 1: 1,0,0 pattern, other: random
    task automatic feed_block(input logic [511:0] blk, input bit last, input int mode);
        int n = 0;
        int k = 0;
        bit v;
        while (n < 16 && k < 400) begin
            @(negedge clk);
            case (mode)
                0:       v = 1'b1;
                1:       v = (k % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_word  = v ? blk[511 - 32*n -: 32] : $urandom;
            in_last  = (n == 15) ? last : 1'($urandom);
            start    = (n == pulse_word);
            #1;
            if (v && in_ready) n++;
            k++;
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        if (n < 16) begin
            $display("FAIL feed_block: accepted %0d words, required 16", n);
            $fatal(1);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (done === 1'b1) begin ok = 1'b1; return; end
        end
    endtask

    task automatic wait_round(input logic [5:0] r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (comp_en === 1'b1 && round === r) begin ok = 1'b1; return; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        in_valid = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk_cnt++; if (digest !== '0) $display("FAIL reset_digest: got %h required 0", digest); else pass_cnt++;
        chk_cnt++; if (digest_valid !== 1'b0) $display("FAIL reset_digest_valid: got %b required 0", digest_valid); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b required 0", done); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b required 0", in_ready); else pass_cnt++;
        chk_cnt++; if (msg_we !== 1'b0) $display("FAIL reset_msg_we: got %b required 0", msg_we); else pass_cnt++;
        chk_cnt++; if (comp_en !== 1'b0) $display("FAIL reset_comp_en: got %b required 0", comp_en); else pass_cnt++;
        chk_cnt++; if (comp_init !== 1'b0) $display("FAIL reset_comp_init: got %b required 0", comp_init); else pass_cnt++;
        chk_cnt++; if (round !== 6'd0) $display("FAIL reset_round: got %0d required 0", round); else pass_cnt++;
        chk_cnt++; if (msg_addr !== 4'd0) $display("FAIL reset_msg_addr: got %0d required 0", msg_addr); else pass_cnt++;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abc();
        bit ok;
        int base = done_cnt;
        do_start();
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL abc_start_latency: in_ready got %b required 1", in_ready); else pass_cnt++;
        feed_block(ABC_BLK, 1'b1, 0);
        wait_done(ok);
        chk_cnt++; if (!ok) $display("FAIL abc_done_timeout: done not seen, required pulse"); else pass_cnt++;
        chk_cnt++; if (digest !== ABC_DIG) $display("FAIL abc_digest: got %h required %h", digest, ABC_DIG); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if (t_done - t_last !== int'(ROUNDS) + 3) $display("FAIL abc_done_latency: got %0d required %0d", t_done - t_last, ROUNDS + 3); else pass_cnt++;
        chk_cnt++; if (digest_valid !== 1'b1) $display("FAIL abc_digest_valid: got %b required 1", digest_valid); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abc_idle_after: done %b busy %b required 0 0", done, busy); else pass_cnt++;
        chk_cnt++; if (done_cnt - base !== 1) $display("FAIL abc_done_count: got %0d required 1", done_cnt - base); else pass_cnt++;
    endtask

    task automatic test_two_block();
        bit ok;
        int base = done_cnt;
        int tl1;
        do_start();
        feed_block(TWO_B1, 1'b0, 0);
        tl1 = t_last;
        feed_block(TWO_B2, 1'b1, 0);
        chk_cnt++; if (t_first - tl1 !== int'(ROUNDS) + 3) $display("FAIL two_reload_latency: got %0d required %0d", t_first - tl1, ROUNDS + 3); else pass_cnt++;
        wait_done(ok);
        chk_cnt++; if (!ok) $display("FAIL two_done_timeout: done not seen, required pulse"); else pass_cnt++;
        chk_cnt++; if (digest !== TWO_DIG) $display("FAIL two_digest: got %h required %h", digest, TWO_DIG); else pass_cnt++;
        repeat (5) @(negedge clk);
        chk_cnt++; if (done_cnt - base !== 1) $display("FAIL two_done_count: got %0d required 1", done_cnt - base); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit ok;
        bit v;
        int n = 0;
        int k = 0;
        int lb;
        logic [511:0] blk = rand_block();
        logic [255:0] exp = sha_compress(IV_V, blk);
        do_start();
        lb = addr_log.size();
        while (n < 16 && k < 100) begin
            @(negedge clk);
            v = (k % 3 == 0);
            in_valid = v;
            in_word  = v ? blk[511 - 32*n -: 32] : $urandom;
            in_last  = (n == 15) ? 1'b1 : 1'($urandom);
            #1;
            chk_cnt++; if (msg_we !== v) $display("FAIL bp_msg_we: got %b required %b at word %0d", msg_we, v, n); else pass_cnt++;
            if (v) begin
                chk_cnt++; if (msg_addr !== 4'(n)) $display("FAIL bp_msg_addr: got %0d required %0d", msg_addr, n); else pass_cnt++;
            end
            if (v && in_ready) n++;
            k++;
        end
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
        chk_cnt++; if (addr_log.size() - lb !== 16) $display("FAIL bp_write_count: got %0d required 16", addr_log.size() - lb); else pass_cnt++;
        wait_done(ok);
        chk_cnt++; if (!ok) $display("FAIL bp_done_timeout: done not seen, required pulse"); else pass_cnt++;
        chk_cnt++; if (digest !== exp) $display("FAIL bp_digest: got %h required %h", digest, exp); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        bit ok;
        logic [255:0] exp;
        for (int i = 0; i < 8; i++) exp[i*32 +: 32] = IV_V[i*32 +: 32] - 32'd1;
        force_ones = 1'b1;
        do_start();
        #1;
        chk_cnt++; if (digest_valid !== 1'b0) $display("FAIL wrap_valid_cleared: got %b required 0", digest_valid); else pass_cnt++;
        feed_block(rand_block(), 1'b1, 2);
        wait_done(ok);
        chk_cnt++; if (!ok) $display("FAIL wrap_done_timeout: done not seen, required pulse"); else pass_cnt++;
        chk_cnt++; if (digest !== exp) $display("FAIL wrap_digest: got %h required %h", digest, exp); else pass_cnt++;
        @(negedge clk);
        force_ones = 1'b0;
    endtask

    task automatic test_start_busy();
        bit ok;
        int base = done_cnt;
        int lb;
        logic [511:0] b1 = rand_block();
        logic [511:0] b2 = rand_block();
        logic [255:0] exp = sha_compress(sha_compress(IV_V, b1), b2);
        do_start();
        lb = addr_log.size();
        feed_block(b1, 1'b0, 0);
        pulse_word = 6;
        feed_block(b2, 1'b1, 0);
        pulse_word = -1;
        for (int j = 0; j < 32; j++) begin
            if (lb + j < addr_log.size()) begin
                chk_cnt++; if (addr_log[lb + j] !== 4'(j % 16)) $display("FAIL busy_addr_seq: got %0d required %0d at %0d", addr_log[lb + j], j % 16, j); else pass_cnt++;
            end
        end
        wait_round(6'd10, ok);
        start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        chk_cnt++; if (!ok || round !== 6'd11 || comp_en !== 1'b1) $display("FAIL busy_round_pulse: round %0d comp_en %b required 11 1", round, comp_en); else pass_cnt++;
        wait_round(6'(ROUNDS - 1), ok);
        @(negedge clk); start = 1'b1; #1;
        chk_cnt++; if (!ok || comp_en !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL busy_update_cycle: comp_en %b busy %b in_ready %b required 0 1 0", comp_en, busy, in_ready); else pass_cnt++;
        @(negedge clk); start = 1'b0; #1;
        chk_cnt++; if (done !== 1'b1) $display("FAIL busy_done_after_update: got %b required 1", done); else pass_cnt++;
        chk_cnt++; if (digest !== exp) $display("FAIL busy_digest: got %h required %h", digest, exp); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if (digest_valid !== 1'b1 || busy !== 1'b0) $display("FAIL busy_final_state: valid %b busy %b required 1 0", digest_valid, busy); else pass_cnt++;
        chk_cnt++; if (done_cnt - base !== 1) $display("FAIL busy_done_count: got %0d required 1", done_cnt - base); else pass_cnt++;
    endtask

    task automatic test_random_messages();
        bit ok;
        for (int m = 0; m < 3; m++) begin
            int base = done_cnt;
            int nb = $urandom_range(1, 3);
            logic [255:0] exp = IV_V;
            do_start();
            for (int b = 0; b < nb; b++) begin
                logic [511:0] blk = rand_block();
                exp = sha_compress(exp, blk);
                feed_block(blk, b == nb - 1, 2);
            end
            wait_done(ok);
            chk_cnt++; if (!ok) $display("FAIL rand_done_timeout: msg %0d done not seen, required pulse", m); else pass_cnt++;
            chk_cnt++; if (digest !== exp) $display("FAIL rand_digest: msg %0d got %h required %h", m, digest, exp); else pass_cnt++;
            @(negedge clk);
            chk_cnt++; if (t_done - t_last !== int'(ROUNDS) + 3) $display("FAIL rand_done_latency: got %0d required %0d", t_done - t_last, ROUNDS + 3); else pass_cnt++;
            chk_cnt++; if (done_cnt - base !== 1) $display("FAIL rand_done_count: got %0d required 1", done_cnt - base); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_start();
        feed_block(ABC_BLK, 1'b1, 0);
        wait_round(6'd30, ok);
        chk_cnt++; if (!ok) $display("FAIL rst_mid_reach_round: round 30 not reached, required"); else pass_cnt++;
        reset_n = 1'b0;
        #1;
        chk_cnt++; if (busy !== 1'b0 || comp_en !== 1'b0 || round !== 6'd0) $display("FAIL rst_mid_ctrl: busy %b comp_en %b round %0d required 0 0 0", busy, comp_en, round); else pass_cnt++;
        chk_cnt++; if (digest !== '0 || digest_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) $display("FAIL rst_mid_outputs: digest %h valid %b done %b ready %b required all 0", digest, digest_valid, done, in_ready); else pass_cnt++;
        @(negedge clk); reset_n = 1'b1;
        do_start();
        feed_block(ABC_BLK, 1'b1, 0);
        wait_done(ok);
        chk_cnt++; if (!ok) $display("FAIL rst_mid_done_timeout: done not seen, required pulse"); else pass_cnt++;
        chk_cnt++; if (digest !== ABC_DIG) $display("FAIL rst_mid_digest: got %h required %h", digest, ABC_DIG); else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_abc();
        test_two_block();
        test_backpressure();
        test_wrap();
        test_start_busy();
        test_random_messages();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
